vector_recorder: RTL and testbench



---
 rtl/vrec_pkg.sv | 58 +++++
 rtl/vrec_fifo.sv | 50 +++++
 rtl/vector_recorder.sv | 113 +++++++++++
 tb/tb_vector_recorder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vrec_pkg.sv
// Shared definitions for vector_recorder: record field layout, mismatch bit
// indices and saturating counter arithmetic.
package vrec_pkg;

  localparam int unsigned MISM_GATE = 2;
  localparam int unsigned MISM_DATA = 1;
  localparam int unsigned MISM_BEH  = 0;
  localparam int unsigned MISM_W    = 3;

  // Record layout, MSB to LSB: ts | mism | stim | y_gate | y_data | y_beh | y_expected
  function automatic int unsigned rec_width(int unsigned in_w, int unsigned out_w,
                                            int unsigned ts_w);
    return ts_w + MISM_W + in_w + 4 * out_w;
  endfunction

  function automatic int unsigned off_expected();
    return 0;
  endfunction

  function automatic int unsigned off_beh(int unsigned out_w);
    return out_w;
  endfunction

  function automatic int unsigned off_data(int unsigned out_w);
    return 2 * out_w;
  endfunction

  function automatic int unsigned off_gate(int unsigned out_w);
    return 3 * out_w;
  endfunction

  function automatic int unsigned off_stim(int unsigned out_w);
    return 4 * out_w;
  endfunction

  function automatic int unsigned off_mism(int unsigned in_w, int unsigned out_w);
    return 4 * out_w + in_w;
  endfunction

  function automatic int unsigned off_ts(int unsigned in_w, int unsigned out_w);
    return 4 * out_w + in_w + MISM_W;
  endfunction

  function automatic logic [1:0] popcount3(logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  // Adds inc to v, clamping at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_add(logic [63:0] v, logic [63:0] inc, int unsigned w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum   = v + inc;
    if ((sum < v) || (sum > max_v)) return max_v;
    return sum;
  endfunction

endpackage

// File: rtl/vrec_fifo.sv
// First-word-fall-through record FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module vrec_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage is reset too, so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/vector_recorder.sv
// Response recorder: timestamps each sample, flags UUT mismatches, keeps
// saturating totals and queues records. Define VREC_ERRORS_ONLY_EN to queue
// only mismatching samples.
module vector_recorder
  import vrec_pkg::*;
#(
  parameter int unsigned IN_W  = 1,
  parameter int unsigned OUT_W = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 32
) (
  input  logic                                      tick,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      sample_en,
  input  logic [IN_W-1:0]                           stim,
  input  logic [OUT_W-1:0]                          y_gate,
  input  logic [OUT_W-1:0]                          y_data,
  input  logic [OUT_W-1:0]                          y_beh,
  input  logic [OUT_W-1:0]                          y_expected,
  output logic                                      rec_valid,
  input  logic                                      rec_ready,
  output logic [rec_width(IN_W, OUT_W, TS_W)-1:0]   rec_data,
  output logic [TS_W-1:0]                           vector_count,
  output logic [TS_W-1:0]                           error_count,
  output logic                                      overflow
);

  localparam int unsigned REC_W = rec_width(IN_W, OUT_W, TS_W);

  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  vcnt_q;
  logic [TS_W-1:0]  ecnt_q;
  logic             ovf_q;
  logic [2:0]       mism;
  logic [REC_W-1:0] rec_in;
  logic             keep;
  logic             push_req;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  always_comb begin
    mism            = '0;
    mism[MISM_GATE] = (y_gate != y_expected);
    mism[MISM_DATA] = (y_data != y_expected);
    mism[MISM_BEH]  = (y_beh  != y_expected);
  end

  always_comb begin
    rec_in                                  = '0;
    rec_in[off_expected()        +: OUT_W]  = y_expected;
    rec_in[off_beh(OUT_W)        +: OUT_W]  = y_beh;
    rec_in[off_data(OUT_W)       +: OUT_W]  = y_data;
    rec_in[off_gate(OUT_W)       +: OUT_W]  = y_gate;
    rec_in[off_stim(OUT_W)       +: IN_W]   = stim;
    rec_in[off_mism(IN_W, OUT_W) +: MISM_W] = mism;
    rec_in[off_ts(IN_W, OUT_W)   +: TS_W]   = ts_q;
  end

`ifdef VREC_ERRORS_ONLY_EN
  assign keep = |mism;
`else
  assign keep = 1'b1;
`endif

  assign push_req  = sample_en && !clear && keep;
  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign drop      = push_req && fifo_full && !pop;

  vrec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (tick),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push_req),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (rec_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge tick or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      vcnt_q <= '0;
      ecnt_q <= '0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      ts_q   <= '0;
      vcnt_q <= '0;
      ecnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (sample_en) begin
        vcnt_q <= TS_W'(sat_add(64'(vcnt_q), 64'd1, TS_W));
        ecnt_q <= TS_W'(sat_add(64'(ecnt_q), 64'(popcount3(mism)), TS_W));
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign vector_count = vcnt_q;
  assign error_count  = ecnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_vector_recorder.sv
// Scoreboard bench for vector_recorder: a queue-based reference model predicts
// records and totals; a negedge monitor compares whatever the DUT presents.
module tb_vector_recorder;

  localparam int unsigned IN_W  = 1;
  localparam int unsigned OUT_W = 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned REC_W = TS_W + 3 + IN_W + 4 * OUT_W;
  localparam longint     MAXC  = (64'd1 << TS_W) - 1;

  logic             tick = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             sample_en;
  logic [IN_W-1:0]  stim;
  logic [OUT_W-1:0] y_gate, y_data, y_beh, y_expected;
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic [TS_W-1:0]  vector_count;
  logic [TS_W-1:0]  error_count;
  logic             overflow;

  vector_recorder #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .tick         (tick),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample_en    (sample_en),
    .stim         (stim),
    .y_gate       (y_gate),
    .y_data       (y_data),
    .y_beh        (y_beh),
    .y_expected   (y_expected),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .vector_count (vector_count),
    .error_count  (error_count),
    .overflow     (overflow)
  );

  always #5 tick = ~tick;

  int tests  = 0;
  int failed = 0;
  int pops   = 0;

  // Reference model state
  logic [REC_W-1:0] exp_q[$];
  longint m_ts = 0, m_vc = 0, m_ec = 0;
  bit     m_ovf = 1'b0;

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Golden gate function for the selected stimulus width.
  function automatic logic [OUT_W-1:0] golden(logic [IN_W-1:0] s);
    if (IN_W == 1) return OUT_W'(~s[0]);
    if (IN_W == 2) return OUT_W'(~(|s));
    return OUT_W'(~(&s));
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    m_ts = 0; m_vc = 0; m_ec = 0; m_ovf = 1'b0;
  end

  // Model: evaluated at each active edge from the inputs held during that cycle.
  always @(posedge tick) begin
    if (rst_n === 1'b1) begin
      if (clear) begin
        exp_q.delete();
        m_ts = 0; m_vc = 0; m_ec = 0; m_ovf = 1'b0;
      end else begin
        if (sample_en) begin
          logic [2:0] mm;
          int nerr;
          bit keep;
          mm   = {y_gate != y_expected, y_data != y_expected, y_beh != y_expected};
          nerr = int'(mm[0]) + int'(mm[1]) + int'(mm[2]);
          m_vc = (m_vc + 1 > MAXC) ? MAXC : m_vc + 1;
          m_ec = (m_ec + nerr > MAXC) ? MAXC : m_ec + nerr;
`ifdef VREC_ERRORS_ONLY_EN
          keep = (nerr != 0);
`else
          keep = 1'b1;
`endif
          // Queue already reflects this cycle's pop (taken by the monitor).
          if (keep) begin
            if (exp_q.size() < DEPTH)
              exp_q.push_back({TS_W'(m_ts), mm, stim, y_gate, y_data, y_beh, y_expected});
            else
              m_ovf = 1'b1;
          end
        end
        m_ts = (m_ts + 1) % (MAXC + 1);
      end
    end
  end

  // Monitor
  always @(negedge tick) begin
    if (rst_n === 1'b0) begin
      chk("reset rec_valid", rec_valid, 0);
      chk("reset rec_data", rec_data, 0);
      chk("reset vector_count", vector_count, 0);
      chk("reset error_count", error_count, 0);
      chk("reset overflow", overflow, 0);
    end else if (rst_n === 1'b1) begin
      chk("rec_valid", rec_valid, exp_q.size() != 0);
      if (rec_valid && exp_q.size() != 0) begin
        chk("rec_data", rec_data, exp_q[0]);
        if (rec_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      chk("vector_count", vector_count, m_vc);
      chk("error_count", error_count, m_ec);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic drv(input bit s, input logic [IN_W-1:0] st, input logic [2:0] wrong,
                     input bit rdy, input bit clr);
    logic [OUT_W-1:0] e;
    @(posedge tick);
    #1;
    e          = golden(st);
    sample_en  = s;
    stim       = st;
    y_expected = e;
    y_gate     = wrong[2] ? ~e : e;
    y_data     = wrong[1] ? ~e : e;
    y_beh      = wrong[0] ? ~e : e;
    rec_ready  = rdy;
    clear      = clr;
  endtask

  task automatic idle(input bit rdy);
    drv(1'b0, '0, 3'b000, rdy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_n = 1'b0; clear = 1'b0; sample_en = 1'b0; stim = '0;
    y_gate = '0; y_data = '0; y_beh = '0; y_expected = '0; rec_ready = 1'b0;
    repeat (3) @(posedge tick);
    #1 rst_n = 1'b1;

    // Four correct not1 samples
    for (int i = 0; i < 4; i++) drv(1'b1, IN_W'(i % 2), 3'b000, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge tick);
    chk("phase1 vector_count", vector_count, 4);
    chk("phase1 error_count", error_count, 0);

    // Single and triple mismatches
    drv(1'b1, IN_W'(1), 3'b010, 1'b1, 1'b0);
    drv(1'b1, IN_W'(1), 3'b111, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge tick);
    chk("mismatch error_count", error_count, 4);

    // Overflow with the consumer stalled
    drv(1'b0, '0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) drv(1'b1, IN_W'($urandom), 3'b001, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge tick);
    chk("overflow set", overflow, 1);
    chk("overflow vector_count", vector_count, DEPTH + 2);
    repeat (DEPTH + 2) idle(1'b1);

    // Full FIFO with simultaneous push and pop
    drv(1'b0, '0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drv(1'b1, IN_W'($urandom), 3'b100, 1'b0, 1'b0);
    drv(1'b1, IN_W'($urandom), 3'b100, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge tick);
    chk("full push+pop overflow", overflow, 0);
    repeat (DEPTH + 2) idle(1'b1);

    // Clear with FIFO half full and a concurrent sample
    drv(1'b0, '0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH / 2; i++) drv(1'b1, IN_W'($urandom), 3'b001, 1'b0, 1'b0);
    drv(1'b1, IN_W'($urandom), 3'b001, 1'b0, 1'b1);
    drv(1'b1, IN_W'(1), 3'b001, 1'b1, 1'b0);
    @(negedge tick);
    chk("clear rec_valid", rec_valid, 0);
    chk("clear vector_count", vector_count, 0);
    chk("clear overflow", overflow, 0);
    idle(1'b1);
    @(negedge tick);
    chk("post-clear record timestamp", rec_data[REC_W-1 -: TS_W], 0);
    repeat (2) idle(1'b1);

    // Eight samples, two mismatching
    drv(1'b0, '0, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      drv(1'b1, IN_W'($urandom), (i == 2 || i == 5) ? 3'b010 : 3'b000, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge tick);
    chk("eight-sample vector_count", vector_count, 8);
    p0 = pops;
    repeat (DEPTH + 2) idle(1'b1);
`ifdef VREC_ERRORS_ONLY_EN
    chk("eight-sample records", pops - p0, 2);
`else
    chk("eight-sample records", pops - p0, 8);
`endif

    // Reset mid-stream discards queued records
    for (int i = 0; i < 5; i++) drv(1'b1, IN_W'($urandom), 3'b011, 1'b0, 1'b0);
    @(posedge tick);
    #1 rst_n = 1'b0;
    repeat (2) idle(1'b0);
    @(posedge tick);
    #1 rst_n = 1'b1;

    // Random traffic: timestamp wrap and counter saturation, then sporadic clears
    for (int i = 0; i < 700; i++)
      drv($urandom_range(0, 3) != 0, IN_W'($urandom),
          ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
          $urandom_range(0, 2) != 0,
          (i > 450) && ($urandom_range(0, 99) == 0));

    repeat (DEPTH + 4) idle(1'b1);
    @(negedge tick);
    chk("final queue drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
